// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier datapath.
//   - loader_state_e : operand loader FSM states
//   - DefaultDataW   : default element width
//   - elem_off()     : bit offset of element (row, col) in a row-major flat buffer
package matrix_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StHold  = 2'd2
  } loader_state_e;

  function automatic int unsigned elem_off(int unsigned row, int unsigned col,
                                           int unsigned ncols, int unsigned width);
    return (row * ncols + col) * width;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Element index counter with terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart at 0 and latch a new limit (takes priority over inc)
//   limit    : index of the last element for the next matrix
//   inc      : advance; wraps to 0 after the limit
//   idx      : current element index
//   tc       : idx equals the latched limit
module matrix_index_counter #(
  parameter int unsigned         WIDTH       = 2,
  parameter logic [WIDTH-1:0]    RESET_LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] limit,
  input  logic             inc,
  output logic [WIDTH-1:0] idx,
  output logic             tc
);

  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] lim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      lim_q <= RESET_LIMIT;
    end else if (load) begin
      idx_q <= '0;
      lim_q <= limit;
    end else if (inc) begin
      idx_q <= tc ? '0 : idx_q + 1'b1;
    end
  end

  assign idx = idx_q;
  assign tc  = (idx_q == lim_q);

endmodule

// File: rtl/matrix_operand_loader.sv
// Operand loader for the combinational matrix multiplier.
// Collects a valid/ready element stream into A (ROWS_A x COLS_A) then B (COLS_A x COLS_B),
// row-major, and holds both flat buffers stable under mat_valid until mat_ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : element stream handshake, in_data the element
//   mat_valid/mat_ready : operand pair handshake
//   a_flat, b_flat      : flat operand buffers, element (r,c) at elem_off(r, c, ncols, DATA_W)
// Optional macro LOADER_LAST_CHECK_EN adds in_last (marks final B element) and err_last
// (one-cycle pulse on a framing error; the partial pair is dropped).
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ROWS_A = 2,
  parameter int unsigned COLS_A = 2,
  parameter int unsigned COLS_B = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
`ifdef LOADER_LAST_CHECK_EN
  input  logic                             in_last,
  output logic                             err_last,
`endif
  output logic                             mat_valid,
  input  logic                             mat_ready,
  output logic [ROWS_A*COLS_A*DATA_W-1:0]  a_flat,
  output logic [COLS_A*COLS_B*DATA_W-1:0]  b_flat
);

  localparam int unsigned SizeA   = ROWS_A * COLS_A;
  localparam int unsigned SizeB   = COLS_A * COLS_B;
  localparam int unsigned SizeMax = (SizeA > SizeB) ? SizeA : SizeB;
  localparam int unsigned IdxW    = (SizeMax > 1) ? $clog2(SizeMax) : 1;
  localparam logic [IdxW-1:0] LimA = IdxW'(SizeA - 1);
  localparam logic [IdxW-1:0] LimB = IdxW'(SizeB - 1);

  loader_state_e state_q, state_d;

  logic [SizeA*DATA_W-1:0] a_q;
  logic [SizeB*DATA_W-1:0] b_q;
  logic [IdxW-1:0]         idx;
  logic                    tc;
  logic                    accept;
  logic                    last_bad;
  logic                    wr;
  logic                    cnt_load;
  logic [IdxW-1:0]         cnt_limit;
  logic [31:0]             wr_off;

  assign accept = in_valid & in_ready;

`ifdef LOADER_LAST_CHECK_EN
  logic err_q;

  // in_last must be set on exactly the final B element.
  assign last_bad = accept & (in_last != ((state_q == StLoadB) & tc));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= last_bad;
  end

  assign err_last = err_q;
`else
  assign last_bad = 1'b0;
`endif

  // A mis-framed element is dropped rather than written.
  assign wr     = accept & ~last_bad;
  assign wr_off = elem_off(0, 32'(idx), 1, DATA_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StLoadA;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (last_bad) begin
      state_d = StLoadA;
    end else begin
      case (state_q)
        StLoadA: if (accept && tc) state_d = StLoadB;
        StLoadB: if (accept && tc) state_d = StHold;
        StHold:  if (mat_ready)    state_d = StLoadA;
        default: state_d = StLoadA;
      endcase
    end
  end

  // Outputs depend on the registered state only.
  always_comb begin
    in_ready  = (state_q != StHold);
    mat_valid = (state_q == StHold);
  end

  // Restart the index on every state change and on a framing error.
  assign cnt_load  = last_bad | (state_d != state_q);
  assign cnt_limit = (state_d == StLoadB) ? LimB : LimA;

  matrix_index_counter #(
    .WIDTH       (IdxW),
    .RESET_LIMIT (LimA)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .limit (cnt_limit),
    .inc   (wr),
    .idx   (idx),
    .tc    (tc)
  );

  // Buffers are only written while loading, so they cannot move under mat_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr) begin
      if (state_q == StLoadA) a_q[wr_off +: DATA_W] <= in_data;
      else                    b_q[wr_off +: DATA_W] <= in_data;
    end
  end

  assign a_flat = a_q;
  assign b_flat = b_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        err_last;
  logic        mat_valid;
  logic        mat_ready;
  logic [63:0] a_flat;
  logic [63:0] b_flat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  matrix_operand_loader #(
    .DATA_W (16),
    .ROWS_A (2),
    .COLS_A (2),
    .COLS_B (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef LOADER_LAST_CHECK_EN
    .in_last   (in_last),
    .err_last  (err_last),
`endif
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .a_flat    (a_flat),
    .b_flat    (b_flat)
  );

`ifndef LOADER_LAST_CHECK_EN
  assign err_last = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        last;
    logic        mr;
    logic        exp_rdy;
    logic        exp_mv;
    logic        chk;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  // Four consecutive values b..b+3 packed row-major, element 0 in the low bits.
  function automatic logic [63:0] pk(int b);
    return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
  endfunction

  function automatic void add(logic r, logic v, int d, logic l, logic mr, logic rdy, logic mv,
                              logic chk, logic [63:0] ea, logic [63:0] eb);
    vec_t x;
    x.rst = r; x.v = v; x.d = 16'(d); x.last = l; x.mr = mr;
    x.exp_rdy = rdy; x.exp_mv = mv; x.chk = chk; x.exp_a = ea; x.exp_b = eb;
    vecs.push_back(x);
  endfunction

  // Eight back-to-back elements base..base+7, in_last on the eighth.
  function automatic void stream(int base, logic mr);
    for (int i = 0; i < 8; i++) add(0, 1, base + i, i == 7, mr, 1, 0, 0, '0, '0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(int d, logic l);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0;
  endtask

  initial begin
    // Test 1: 1..8 back-to-back, consumer always ready
    stream(1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(1), pk(5));
    add(0, 0, 0, 0, 1, 1, 0, 1, pk(1), pk(5));
    // Test 2: consumer stalls 5 cycles; in_valid held high with junk must be ignored
    stream(31, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 16'hbeef, 0, 0, 0, 1, 1, pk(31), pk(35));
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(31), pk(35));
    add(0, 0, 0, 0, 1, 1, 0, 1, pk(31), pk(35));
    // Test 3: in_valid pattern 1,0,0,1,... with junk data in the gaps
    for (int e = 0; e < 8; e++) begin
      add(0, 1, e + 1, e == 7, 1, 1, 0, 0, '0, '0);
      if (e < 7) begin
        add(0, 0, 16'hdead, 0, 1, 1, 0, 0, '0, '0);
        add(0, 0, 16'hdead, 0, 1, 1, 0, 0, '0, '0);
      end
    end
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(1), pk(5));
    add(0, 0, 0, 0, 1, 1, 0, 0, '0, '0);
    // Test 4: reset after three accepts clears everything, then 11..18
    for (int i = 0; i < 3; i++) add(0, 1, 41 + i, 0, 1, 1, 0, 0, '0, '0);
    add(1, 0, 0, 0, 1, 1, 0, 0, '0, '0);
    add(0, 0, 0, 0, 1, 1, 0, 1, '0, '0);
    stream(11, 1);
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(11), pk(15));
    // Test 5: two pairs back-to-back, second stream starts in the idle cycle
    stream(1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(1), pk(5));
    stream(21, 1);
    add(0, 0, 0, 0, 1, 0, 1, 1, pk(21), pk(25));
    add(0, 0, 0, 0, 1, 1, 0, 1, pk(21), pk(25));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mat_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_mat_valid", 64'(mat_valid), 64'd0);
    check("reset_a_flat", a_flat, 64'd0);
    check("reset_b_flat", b_flat, 64'd0);
    check("reset_err_last", 64'(err_last), 64'd0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; in_valid = vecs[i].v; in_data = vecs[i].d;
      in_last = vecs[i].last; mat_ready = vecs[i].mr;
      #1;
      check($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
      check($sformatf("row%0d_mat_valid", i), 64'(mat_valid), 64'(vecs[i].exp_mv));
`ifdef LOADER_LAST_CHECK_EN
      check($sformatf("row%0d_err_last", i), 64'(err_last), 64'd0);
`endif
      if (vecs[i].chk) begin
        check($sformatf("row%0d_a_flat", i), a_flat, vecs[i].exp_a);
        check($sformatf("row%0d_b_flat", i), b_flat, vecs[i].exp_b);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;

    // Latency: mat_valid must be visible right after the final B accept
    mat_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(61 + i, i == 7);
    begin
      int waited = 0;
      while (!mat_valid && waited < 4) begin
        @(posedge clk); #1;
        waited++;
      end
      check("latency_cycles", 64'(waited), 64'd0);
    end
    check("latency_a_flat", a_flat, pk(61));
    check("latency_b_flat", b_flat, pk(65));
    mat_ready = 1'b1;
    @(posedge clk); #1;
    check("release_mat_valid", 64'(mat_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);

`ifdef LOADER_LAST_CHECK_EN
    // Early in_last on element 5 aborts the pair
    for (int i = 0; i < 5; i++) send(1 + i, i == 4);
    check("early_last_err", 64'(err_last), 64'd1);
    check("early_last_mv", 64'(mat_valid), 64'd0);
    @(posedge clk); #1;
    check("early_last_err_pulse", 64'(err_last), 64'd0);
    check("early_last_mv_after", 64'(mat_valid), 64'd0);
    for (int i = 0; i < 8; i++) send(1 + i, i == 7);
    check("recover_mv", 64'(mat_valid), 64'd1);
    check("recover_err", 64'(err_last), 64'd0);
    check("recover_a_flat", a_flat, pk(1));
    check("recover_b_flat", b_flat, pk(5));
    @(posedge clk); #1;
    // Missing in_last on the final element aborts the pair
    for (int i = 0; i < 8; i++) send(71 + i, 1'b0);
    check("missing_last_err", 64'(err_last), 64'd1);
    check("missing_last_mv", 64'(mat_valid), 64'd0);
    check("missing_last_b_flat", b_flat[63:48], 64'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
